// File: rtl/amba3_apb_slave_regs.sv
// amba3_apb_slave_regs: AMBA 3 APB completer exposing a register bank
// with a read-only ID register, wait-state insertion and error/abort handling.
module amba3_apb_slave_regs #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int NUM_REGS = 16,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
    parameter int WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE = 32'hA3B0_0001
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic [ADDR_SIZE-1:0] paddr,
    input  logic                 pwrite,
    input  logic [DATA_SIZE-1:0] pwdata,
    output logic                 pready,
    output logic [DATA_SIZE-1:0] prdata,
    output logic                 pslverr,
    output logic                 wr_strobe,
    output logic [7:0]           wr_index,
    output logic                 prot_err
);
    localparam int BSHIFT = $clog2(DATA_SIZE / 8);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((1 << BSHIFT) - 1);
    localparam logic [63:0] ID_EXT = {32'h0, ID_VALUE};
    localparam logic [DATA_SIZE-1:0] ID_WORD = ID_EXT[DATA_SIZE-1:0];
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] idx_q;
    logic wr_q, err_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [DATA_SIZE-1:0] regs [1:NUM_REGS-1];

    logic [ADDR_SIZE:0] diff;
    logic [ADDR_SIZE-1:0] off, idx_full;
    logic [7:0] idx_dec, rd_idx;
    logic err_dec, rd_err, rd_wr;
    logic [DATA_SIZE-1:0] rd_val;
    logic latch, commit, resp_d, prot_d;
    logic pready_d, pslverr_d;
    logic [DATA_SIZE-1:0] prdata_d;

    // Address decode of the current bus; the borrow flags addresses below the bank
    always_comb begin
        diff = {1'b0, paddr} - {1'b0, BASE_ADDR};
        off = diff[ADDR_SIZE-1:0];
        idx_full = off >> BSHIFT;
        idx_dec = idx_full[7:0];
        err_dec = diff[ADDR_SIZE]
                | ((off & ALIGN_MASK) != '0)
                | (idx_full >= ADDR_SIZE'(NUM_REGS))
                | (pwrite & (idx_full == '0));
    end

    // Entering RESP straight from IDLE uses the live decode, otherwise the latch
    always_comb begin
        if (state_q == S_IDLE) begin
            rd_idx = idx_dec;
            rd_err = err_dec;
            rd_wr = pwrite;
        end else begin
            rd_idx = idx_q;
            rd_err = err_q;
            rd_wr = wr_q;
        end
    end

    // Register read mux; index 0 is the constant ID word
    always_comb begin
        rd_val = ID_WORD;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_idx == 8'(i)) rd_val = regs[i];
        end
    end

    // Next-state, protocol checking and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        latch = 1'b0;
        commit = 1'b0;
        resp_d = 1'b0;
        prot_d = prot_err;
        pready_d = 1'b0;
        pslverr_d = 1'b0;
        prdata_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (psel & ~penable) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        resp_d = 1'b1;
                    end else begin
                        cnt_d = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end else if (psel & penable) begin
                    prot_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (~psel | ~penable) begin
                    state_d = S_IDLE;
                    prot_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    resp_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (psel & penable) commit = wr_q & ~err_q;
                else prot_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (resp_d) begin
            pready_d = 1'b1;
            pslverr_d = rd_err;
            prdata_d = (rd_wr | rd_err) ? '0 : rd_val;
        end
    end

    // FSM state, setup-phase latch and registered bus outputs
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= S_IDLE;
            cnt_q <= 4'd0;
            idx_q <= 8'd0;
            wr_q <= 1'b0;
            err_q <= 1'b0;
            wdata_q <= '0;
            pready <= 1'b0;
            prdata <= '0;
            pslverr <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index <= 8'd0;
            prot_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (latch) begin
                idx_q <= idx_dec;
                wr_q <= pwrite;
                err_q <= err_dec;
                wdata_q <= pwdata;
            end
            pready <= pready_d;
            prdata <= prdata_d;
            pslverr <= pslverr_d;
            wr_strobe <= commit;
            if (commit) wr_index <= idx_q;
            prot_err <= prot_d;
        end
    end

    // Register bank; only error-free completed writes land here
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (idx_q == 8'(i)) regs[i] <= wdata_q;
            end
        end
    end
endmodule
